// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one registered ALU between the main datapath
//               (requester 0) and the branch/address unit (requester 1).
//               The arbiter grants round-robin, latches the winner's operands,
//               drives the ALU for a single issue cycle and returns the
//               result on a tagged response channel.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DW = 32,
    parameter int SW = 5,
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req0_b,
    input  logic [DW-1:0] req1_b,
    input  logic [SW-1:0] req0_shamt,
    input  logic [SW-1:0] req1_shamt,
    input  logic [FW-1:0] req0_funct,
    input  logic [FW-1:0] req1_funct,

    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [SW-1:0] alu_shamt,
    output logic [FW-1:0] alu_funct,
    input  logic [DW-1:0] alu_res,

    output logic          resp_valid,
    input  logic          resp_ready,
    output logic          resp_id,
    output logic [DW-1:0] resp_data,
    output logic          resp_err,

    output logic          busy
);

    // State encoding: IDLE accepts, ISSUE drives the ALU, RESP presents the result.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;

    logic [1:0]    r_state;
    logic          r_last_grant;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [SW-1:0] r_shamt;
    logic [FW-1:0] r_funct;
    logic          r_id;
    logic          r_err;

    logic          w_grant_id;
    logic          w_accept;
    logic [DW-1:0] w_sel_a;
    logic [DW-1:0] w_sel_b;
    logic [SW-1:0] w_sel_shamt;
    logic [FW-1:0] w_sel_funct;
    logic          w_sel_illegal;

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // requester that did not win the previous transfer.
    always_comb begin
        w_grant_id = req_valid[1];
        if (req_valid == 2'b11) begin
            w_grant_id = ~r_last_grant;
        end
    end

    assign w_accept  = (r_state == c_ST_IDLE) && (|req_valid);
    assign req_ready = w_accept ? (w_grant_id ? 2'b10 : 2'b01) : 2'b00;

    // Operand mux for the granted requester.
    always_comb begin
        w_sel_a     = req0_a;
        w_sel_b     = req0_b;
        w_sel_shamt = req0_shamt;
        w_sel_funct = req0_funct;
        if (w_grant_id) begin
            w_sel_a     = req1_a;
            w_sel_b     = req1_b;
            w_sel_shamt = req1_shamt;
            w_sel_funct = req1_funct;
        end
    end

    // funct 0 means "hold" to the ALU, so a request carrying it is illegal.
    assign w_sel_illegal = (w_sel_funct == '0);

    // Control FSM plus operand/tag latches; last_grant moves only on a transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_shamt      <= '0;
            r_funct      <= '0;
            r_id         <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_b;
                        r_shamt      <= w_sel_shamt;
                        r_funct      <= w_sel_funct;
                        r_id         <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        r_err        <= w_sel_illegal;
                        r_state      <= w_sel_illegal ? c_ST_RESP : c_ST_ISSUE;
                    end
                end
                c_ST_ISSUE: begin
                    r_state <= c_ST_RESP;
                end
                c_ST_RESP: begin
                    if (resp_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // The ALU only sees a live function code during ISSUE; elsewhere it holds res.
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_shamt = r_shamt;
    assign alu_funct = (r_state == c_ST_ISSUE) ? r_funct : '0;

    // Response channel is a pure decode of the registered state and latches.
    assign resp_valid = (r_state == c_ST_RESP);
    assign resp_id    = r_id;
    assign resp_err   = r_err;
    assign resp_data  = r_err ? '0 : alu_res;
    assign busy       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a behavioural ALU,
//               table-driven single ops, directed corner sequences and a
//               cycle monitor backed by a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int SW = 5;
    localparam int FW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [DW-1:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
    logic [SW-1:0] req0_shamt = '0, req1_shamt = '0;
    logic [FW-1:0] req0_funct = '0, req1_funct = '0;
    logic [DW-1:0] alu_a, alu_b;
    logic [SW-1:0] alu_shamt;
    logic [FW-1:0] alu_funct;
    logic [DW-1:0] alu_res = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic          resp_id;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DW(DW), .SW(SW), .FW(FW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
        .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
        .req0_funct(req0_funct), .req1_funct(req1_funct),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_funct(alu_funct), .alu_res(alu_res),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
    );

    // Behavioural ALU function table (1 ADD, 2 SUB, 3 INC by 4, 4 SLA, ...).
    function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [SW-1:0] sh, input logic [FW-1:0] f);
        case (f)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a + 32'd4;
            4'd4:    return a << sh;
            4'd5:    return a >> sh;
            4'd6:    return a & b;
            4'd7:    return a | b;
            4'd8:    return a ^ b;
            default: return a + b + {{(DW-FW){1'b0}}, f};
        endcase
    endfunction

    // Registered ALU that holds its result while funct is 0.
    always @(posedge clk) begin
        if (alu_funct != '0) alu_res <= alu_fn(alu_a, alu_b, alu_shamt, alu_funct);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ops(input logic id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [SW-1:0] sh, input logic [FW-1:0] f);
        if (id) begin
            req1_a = a; req1_b = b; req1_shamt = sh; req1_funct = f;
        end else begin
            req0_a = a; req0_b = b; req0_shamt = sh; req0_funct = f;
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: one outstanding transaction, tracked by cycles since
    // its accept edge; expectations derive from the protocol rules.
    // ------------------------------------------------------------------
    logic          m_out = 1'b0;
    int            m_cnt = 0;
    logic          m_last = 1'b1;
    logic          m_id = 1'b0;
    logic          m_err = 1'b0;
    logic [DW-1:0] m_a, m_b, m_data;
    logic [SW-1:0] m_sh;
    logic [FW-1:0] m_f;
    logic          post_rst = 1'b0;
    logic [1:0]    xfer_seen = 2'b00;
    logic [1:0]    e_rdy;
    logic          e_rv;
    logic [FW-1:0] e_f;
    logic          gid;

    // Cycle monitor: checks every DUT output against the model mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_out    = 1'b0;
            m_last   = 1'b1;
            post_rst = 1'b1;
            xfer_seen = 2'b00;
        end else begin
            if (post_rst) begin
                chk("rst_resp_valid", resp_valid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_resp_id", resp_id, 0);
                chk("rst_resp_err", resp_err, 0);
                chk("rst_alu_funct", alu_funct, 0);
                chk("rst_alu_a", alu_a, 0);
                chk("rst_alu_b", alu_b, 0);
                chk("rst_alu_shamt", alu_shamt, 0);
                post_rst = 1'b0;
            end
            e_rdy = 2'b00;
            if (!m_out) begin
                if (req_valid == 2'b11) e_rdy = m_last ? 2'b01 : 2'b10;
                else                    e_rdy = req_valid;
            end
            chk("mon_req_ready", req_ready, e_rdy);
            chk("mon_busy", busy, m_out);
            e_rv = m_out && (m_cnt >= (m_err ? 1 : 2));
            chk("mon_resp_valid", resp_valid, e_rv);
            e_f = (m_out && !m_err && m_cnt == 1) ? m_f : '0;
            chk("mon_alu_funct", alu_funct, e_f);
            if (e_f != '0) begin
                chk("mon_alu_a", alu_a, m_a);
                chk("mon_alu_b", alu_b, m_b);
                chk("mon_alu_shamt", alu_shamt, m_sh);
            end
            if (e_rv) begin
                chk("mon_resp_id", resp_id, m_id);
                chk("mon_resp_err", resp_err, m_err);
                chk("mon_resp_data", resp_data, m_data);
            end
            xfer_seen = req_valid & req_ready;
            if (e_rv && resp_ready) begin
                m_out = 1'b0;
            end else if (|(req_valid & e_rdy)) begin
                gid    = e_rdy[1];
                m_out  = 1'b1;
                m_cnt  = 1;
                m_last = gid;
                m_id   = gid;
                m_a    = gid ? req1_a : req0_a;
                m_b    = gid ? req1_b : req0_b;
                m_sh   = gid ? req1_shamt : req0_shamt;
                m_f    = gid ? req1_funct : req0_funct;
                m_err  = (m_f == '0);
                m_data = m_err ? '0 : alu_fn(m_a, m_b, m_sh, m_f);
            end else if (m_out && m_cnt < 3) begin
                m_cnt++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Table-driven single operations
    // ------------------------------------------------------------------
    typedef struct {
        logic          id;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [SW-1:0] sh;
        logic [FW-1:0] f;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        int            exp_lat;
    } vec_t;

    vec_t vecs[8];

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; req_valid = 2'b00; resp_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic do_vec(input vec_t v, input string tag);
        int n;
        @(posedge clk); #1;
        set_ops(v.id, v.a, v.b, v.sh, v.f);
        req_valid[v.id] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[v.id] && n < 20);
        chk({tag, "_accept_cycle"}, n, 1);
        chk({tag, "_ready"}, req_ready, v.id ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        req_valid[v.id] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        chk({tag, "_latency"}, n, v.exp_lat);
        chk({tag, "_data"}, resp_data, v.exp_data);
        chk({tag, "_id"}, resp_id, v.id);
        chk({tag, "_err"}, resp_err, v.exp_err);
        @(posedge clk); #1;
    endtask

    // Both requesters valid at once: record grant and response order.
    logic          gq[$];
    logic          rq_id[$];
    logic [DW-1:0] rq_data[$];

    task automatic run_tie(input string tag);
        int guard;
        logic [1:0] g;
        gq.delete(); rq_id.delete(); rq_data.delete();
        @(posedge clk); #1;
        set_ops(1'b0, 32'd10, 32'd3, 5'd0, 4'd2);
        set_ops(1'b1, 32'd100, 32'd0, 5'd0, 4'd3);
        req_valid = 2'b11;
        guard = 0;
        while (rq_id.size() < 2 && guard < 40) begin
            @(negedge clk); guard++;
            if (req_ready != 2'b00) gq.push_back(req_ready[1]);
            if (resp_valid && resp_ready) begin
                rq_id.push_back(resp_id);
                rq_data.push_back(resp_data);
            end
            g = req_valid & req_ready;
            @(posedge clk); #1;
            req_valid = req_valid & ~g;
        end
        chk({tag, "_timeout"}, guard < 40, 1);
        chk({tag, "_grants"}, gq.size(), 2);
        chk({tag, "_resps"}, rq_id.size(), 2);
        if (gq.size() == 2 && rq_id.size() == 2) begin
            chk({tag, "_grant0"}, gq[0], 0);
            chk({tag, "_grant1"}, gq[1], 1);
            chk({tag, "_resp0_id"}, rq_id[0], 0);
            chk({tag, "_resp0_data"}, rq_data[0], 7);
            chk({tag, "_resp1_id"}, rq_id[1], 1);
            chk({tag, "_resp1_data"}, rq_data[1], 104);
        end
    endtask

    // Random traffic; in continuous mode both ports re-request immediately.
    task automatic run_traffic(input int nops, input bit continuous);
        int done;
        int guard;
        int n;
        logic [FW-1:0] f;
        gq.delete();
        done = 0;
        guard = 0;
        while (done < nops && guard < 3000) begin
            @(posedge clk); #1; guard++;
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && xfer_seen[i]) begin
                    req_valid[i] = 1'b0;
                    gq.push_back(i[0]);
                    done++;
                end
                if (!req_valid[i] && (continuous || $urandom_range(0, 2) != 0)) begin
                    f = continuous ? 4'($urandom_range(1, 15)) : 4'($urandom_range(0, 15));
                    set_ops(i[0], $urandom, $urandom, 5'($urandom_range(0, 31)), f);
                    req_valid[i] = 1'b1;
                end else if (req_valid[i] && !continuous && $urandom_range(0, 7) == 0 && !xfer_seen[i]) begin
                    req_valid[i] = 1'b0;
                end
            end
            resp_ready = continuous ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
        chk("traffic_timeout", guard < 3000, 1);
        req_valid = 2'b00;
        resp_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (busy && n < 50);
        chk("traffic_drain", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{1'b0, 32'd5,          32'd7,          5'd0, 4'd1,  32'd12,         1'b0, 2};
        vecs[1] = '{1'b1, 32'd3,          32'd0,          5'd4, 4'd4,  32'd48,         1'b0, 2};
        vecs[2] = '{1'b0, 32'd55,         32'd66,         5'd3, 4'd0,  32'd0,          1'b1, 1};
        vecs[3] = '{1'b1, 32'd100,        32'd0,          5'd0, 4'd3,  32'd104,        1'b0, 2};
        vecs[4] = '{1'b0, 32'd10,         32'd3,          5'd0, 4'd2,  32'd7,          1'b0, 2};
        vecs[5] = '{1'b1, 32'hF0F0_0000,  32'h0FF0_1234,  5'd0, 4'd8,  32'hFF00_1234,  1'b0, 2};
        vecs[6] = '{1'b0, 32'd0,          32'd1,          5'd0, 4'd2,  32'hFFFF_FFFF,  1'b0, 2};
        vecs[7] = '{1'b1, 32'd1,          32'd2,          5'd0, 4'd15, 32'd18,         1'b0, 2};

        do_reset();
        @(negedge clk);
        chk("reset_req_ready", req_ready, 2'b00);
        chk("reset_resp_valid", resp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_alu_funct", alu_funct, 0);

        for (int i = 0; i < 8; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

        // Ties right after reset, then again: requester 0 wins both times.
        do_reset();
        run_tie("tie_a");
        run_tie("tie_b");

        // Backpressure: SLA from requester 1 held in RESP for five cycles.
        @(posedge clk); #1;
        resp_ready = 1'b0;
        set_ops(1'b1, 32'd3, 32'd0, 5'd4, 4'd4);
        req_valid = 2'b10;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[1] && n < 20);
        chk("bp_accept", req_ready, 2'b10);
        @(posedge clk); #1;
        set_ops(1'b0, 32'd20, 32'd22, 5'd0, 4'd1);
        req_valid = 2'b01;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        chk("bp_latency", n, 2);
        for (int k = 0; k < 5; k++) begin
            chk("bp_resp_valid", resp_valid, 1);
            chk("bp_resp_data", resp_data, 48);
            chk("bp_resp_id", resp_id, 1);
            chk("bp_req_ready", req_ready, 2'b00);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", resp_valid, 1);
        @(negedge clk);
        chk("bp_idle_busy", busy, 0);
        chk("bp_next_grant", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        n = 0;
        do begin @(negedge clk); n++; end while (!resp_valid && n < 20);
        chk("bp_next_data", resp_data, 42);
        chk("bp_next_id", resp_id, 0);
        @(posedge clk); #1;

        // Reset asserted during ISSUE drops the op; a fresh ADD then works.
        set_ops(1'b0, 32'd9, 32'd9, 5'd0, 4'd1);
        req_valid = 2'b01;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 20);
        chk("rst_issue_accept", req_ready, 2'b01);
        @(posedge clk); #1;
        req_valid = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_issue_in_issue", alu_funct, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_issue_resp_valid", resp_valid, 0);
        chk("rst_issue_busy", busy, 0);
        chk("rst_issue_alu_funct", alu_funct, 0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst_issue_no_resp", resp_valid, 0);
        end
        do_vec('{1'b0, 32'd1, 32'd1, 5'd0, 4'd1, 32'd2, 1'b0, 2}, "post_rst_add");

        // Continuous traffic on both ports: grants strictly alternate.
        run_traffic(20, 1'b1);
        chk("alt_count", gq.size() >= 20, 1);
        for (int k = 1; k < gq.size(); k++) chk("alt_grant", gq[k] != gq[k-1], 1);

        // Random traffic with illegal functs, drops and response backpressure.
        run_traffic(40, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
